// File: rtl/parking_pkg.sv
// parking_pkg: shared lane state encoding, BCD digit type and digit-count helper
package parking_pkg;
  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} lane_state_t;
  typedef logic [3:0] bcd_digit_t;
  function automatic int ndigits(int v);
    int n;
    n = 1;
    for (int x = v; x >= 10; x = x / 10) n++;
    return n;
  endfunction
endpackage

// File: rtl/parking_lane_fsm.sv
// parking_lane_fsm: one lane's a/b passage tracker emitting registered inc/dec pulses
module parking_lane_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  output logic inc,
  output logic dec
);
  lane_state_t state_q, state_d;
  logic inc_q, inc_d, dec_q, dec_d;
  logic [1:0] ab;
  assign ab = {a, b};
  assign inc = inc_q;
  assign dec = dec_q;
  // State register plus one-cycle pulse registers; reset drops any partial passage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end
  // Entry walks 10,11,01,00; exit is the mirror image 01,11,10,00
  always_comb begin
    state_d = IDLE;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      IDLE: state_d = ab == 2'b10 ? EN1 : ab == 2'b01 ? EX1 : IDLE;
      EN1:  state_d = ab == 2'b10 ? EN1 : ab == 2'b11 ? EN2 : IDLE;
      EN2:  state_d = ab == 2'b11 ? EN2 : ab == 2'b01 ? EN3 : ab == 2'b10 ? EN1 : IDLE;
      EN3: begin
        state_d = ab == 2'b01 ? EN3 : ab == 2'b11 ? EN2 : IDLE;
        inc_d   = ab == 2'b00;
      end
      EX1:  state_d = ab == 2'b01 ? EX1 : ab == 2'b11 ? EX2 : IDLE;
      EX2:  state_d = ab == 2'b11 ? EX2 : ab == 2'b10 ? EX3 : ab == 2'b01 ? EX1 : IDLE;
      EX3: begin
        state_d = ab == 2'b10 ? EX3 : ab == 2'b11 ? EX2 : IDLE;
        dec_d   = ab == 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/parking_lanes.sv
// parking_lanes: multi-lane occupancy counter with clamping and sticky error; PARKING_BCD_EN adds count_bcd
module parking_lanes
  import parking_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CAPACITY = 99,
  localparam int CNT_W = $clog2(CAPACITY + 1)
`ifdef PARKING_BCD_EN
  , localparam int NDIG = ndigits(CAPACITY)
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clr_err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] inc,
  output logic [LANES-1:0] dec,
  output logic             err
`ifdef PARKING_BCD_EN
  , output logic [4*NDIG-1:0] count_bcd
`endif
);
  localparam int DW = $clog2(LANES + 1) + 1;
  localparam int SW = (CNT_W > DW ? CNT_W : DW) + 2;
  logic [CNT_W-1:0] count_q, count_d;
  logic full_q, empty_q, err_q, err_d, hi, lo;
  logic [DW-1:0] ni, nd;
  logic signed [DW-1:0] delta;
  logic signed [SW-1:0] sum;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    parking_lane_fsm u_lane (
      .clk(clk), .reset_n(reset_n), .a(a[i]), .b(b[i]), .inc(inc[i]), .dec(dec[i])
    );
  end
  // Net this cycle's pulses, then clamp to [0, CAPACITY]; a clamp beats clr_err
  always_comb begin
    ni = '0;
    nd = '0;
    for (int k = 0; k < LANES; k++) begin
      ni = ni + DW'(inc[k]);
      nd = nd + DW'(dec[k]);
    end
    delta   = $signed(ni - nd);
    sum     = $signed(SW'(count_q)) + SW'(delta);
    hi      = sum > $signed(SW'(CAPACITY));
    lo      = sum[SW-1];
    count_d = hi ? CNT_W'(CAPACITY) : lo ? '0 : sum[CNT_W-1:0];
    err_d   = hi | lo | (err_q & ~clr_err);
  end
  // Occupancy and its flags move together on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= count_d == CNT_W'(CAPACITY);
      empty_q <= count_d == '0;
      err_q   <= err_d;
    end
  end
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;
`ifdef PARKING_BCD_EN
  logic signed [SW-1:0] diff;
  logic signed [5:0] t, c;
  bcd_digit_t dg;
  logic [4*NDIG-1:0] bcd_q, bcd_d;
  // Apply the clamped step (|step| <= LANES < 10) with a single-digit ripple carry/borrow
  always_comb begin
    diff  = $signed(SW'(count_d)) - $signed(SW'(count_q));
    c     = 6'(diff);
    bcd_d = bcd_q;
    t     = '0;
    dg    = '0;
    for (int k = 0; k < NDIG; k++) begin
      dg = bcd_q[4*k +: 4];
      t  = $signed({2'b00, dg}) + c;
      bcd_d[4*k +: 4] = t[5] ? 4'(t + 6'sd10) : t > 6'sd9 ? 4'(t - 6'sd10) : t[3:0];
      c  = t[5] ? -6'sd1 : t > 6'sd9 ? 6'sd1 : 6'sd0;
    end
  end
  // BCD shadow of count, stepping in lockstep
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bcd_q <= '0;
    else bcd_q <= bcd_d;
  end
  assign count_bcd = bcd_q;
`endif
endmodule
